// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide over XLEN cycles, with sign fix-up and a held result.
module riscv_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    // state | meaning
    // IDLE  | waiting for operands, in_ready=1
    // CALC  | one multiply/divide iteration per cycle, XLEN cycles
    // FIX   | sign correction and half select, result registered
    // DONE  | out_valid held until out_ready
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(XLEN);

    state_t            state_q;
    logic [2:0]        op_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, result_q, fix_res;
    logic              neg_q, special_q, out_valid_q;
    logic [CW-1:0]     cnt_q;

    logic              a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]   a_abs, b_abs, preset;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     mul_sum, div_rem, div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

    assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign a_neg    = a_signed && rs1_data[XLEN-1];
    assign b_neg    = b_signed && rs2_data[XLEN-1];
    assign a_abs    = a_neg ? -rs1_data : rs1_data;
    assign b_abs    = b_neg ? -rs2_data : rs2_data;
    // Remainder follows the dividend; quotient and product follow the sign xor.
    assign neg_in   = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);

    assign div_zero = op[2] && (rs2_data == '0);
    assign div_ovf  = op[2] && !op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                      && (rs2_data == {XLEN{1'b1}});
    assign preset   = div_zero ? (op[1] ? rs1_data : {XLEN{1'b1}})
                               : (op[1] ? '0 : rs1_data);

    // Multiply keeps the multiplier in the low half and shifts the product in
    // from the top; divide keeps the remainder high and the quotient low.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_rem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_rem - {1'b0, opnd_q};
        if (op_q[2]) begin
            acc_d = div_diff[XLEN] ? {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (special_q) begin
            fix_res = acc_q[XLEN-1:0];
        end else if (!op_q[2]) begin
            fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            fix_res = op_q[1] ? rem : quo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            neg_q       <= 1'b0;
            special_q   <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (flush && state_q != IDLE) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && !flush) begin
                        op_q  <= op;
                        neg_q <= neg_in;
                        cnt_q <= '0;
                        if (div_zero || div_ovf) begin
                            special_q <= 1'b1;
                            acc_q     <= {{XLEN{1'b0}}, preset};
                            state_q   <= FIX;
                        end else begin
                            special_q <= 1'b0;
                            acc_q     <= {{XLEN{1'b0}}, op[2] ? a_abs : b_abs};
                            opnd_q    <= op[2] ? b_abs : a_abs;
                            state_q   <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q    <= fix_res;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit at XLEN=32 and XLEN=64: directed
// vectors, latency, hold, back-to-back, flush and reset-abort scenarios.
module tb_riscv_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n, flush, out_ready;
    logic        iv32, iv64;
    logic [2:0]  op_s;
    logic [63:0] a_s, b_s;
    logic        ir32, ov32, ir64, ov64;
    logic [31:0] res32;
    logic [63:0] res64;

    typedef struct {
        logic [63:0] r;
        int          lat;
        int          t;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic ov32_p = 1'b0, ov64_p = 1'b0;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    riscv_muldiv_unit #(.XLEN(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op(op_s),
        .rs1_data(a_s[31:0]), .rs2_data(b_s[31:0]), .flush(flush),
        .out_valid(ov32), .out_ready(out_ready), .result(res32)
    );

    riscv_muldiv_unit #(.XLEN(64)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .op(op_s),
        .rs1_data(a_s), .rs2_data(b_s), .flush(flush),
        .out_valid(ov64), .out_ready(out_ready), .result(res64)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Result and latency are checked when out_valid rises.
    always @(negedge clk) begin
        exp_t e;
        if (ov32 && !ov32_p) begin
            if (q32.size() == 0) begin
                total++; bad++;
                $display("FAIL x32_unexpected_output: got %h want none", res32);
            end else begin
                e = q32.pop_front();
                chk("x32_result", {32'h0, res32}, e.r);
                chk("x32_latency", 64'(cyc - e.t - 1), 64'(e.lat));
            end
        end
        if (ov64 && !ov64_p) begin
            if (q64.size() == 0) begin
                total++; bad++;
                $display("FAIL x64_unexpected_output: got %h want none", res64);
            end else begin
                e = q64.pop_front();
                chk("x64_result", res64, e.r);
                chk("x64_latency", 64'(cyc - e.t - 1), 64'(e.lat));
            end
        end
        ov32_p = ov32;
        ov64_p = ov64;
    end

    // Waits for in_ready, then presents one op for exactly one accepting edge.
    task automatic issue(input int sel, input logic [2:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] e, input bit sp,
                         input bit push);
        int   n = 0;
        exp_t ent;
        @(negedge clk);
        while (!(sel == 0 ? ir32 : ir64) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL issue_timeout: got in_ready=0 want 1 (sel %0d)", sel);
            return;
        end
        op_s = o; a_s = a; b_s = b;
        if (sel == 0) iv32 = 1'b1; else iv64 = 1'b1;
        if (push) begin
            ent.r   = e;
            ent.lat = sp ? 1 : (sel == 0 ? 33 : 65);
            ent.t   = cyc;
            if (sel == 0) q32.push_back(ent); else q64.push_back(ent);
        end
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        iv64 = 1'b0;
    endtask

    task automatic abort_check(input string nm);
        bit seen = 1'b0;
        @(negedge clk);
        chk({nm, "_in_ready"}, {63'h0, ir32}, 64'h1);
        repeat (40) begin
            @(negedge clk);
            if (ov32) seen = 1'b1;
        end
        chk({nm, "_no_output"}, {63'h0, seen}, 64'h0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        iv32 = 1'b0; iv64 = 1'b0; op_s = '0; a_s = '0; b_s = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready32", {63'h0, ir32}, 64'h1);
        chk("rst_out_valid32", {63'h0, ov32}, 64'h0);
        chk("rst_result32", {32'h0, res32}, 64'h0);
        chk("rst_in_ready64", {63'h0, ir64}, 64'h1);
        chk("rst_result64", res64, 64'h0);
        rst_n = 1'b1;

        // flush in IDLE blocks acceptance
        @(negedge clk);
        flush = 1'b1; iv32 = 1'b1; op_s = MUL; a_s = 64'd2; b_s = 64'd2;
        @(negedge clk);
        flush = 1'b0; iv32 = 1'b0;
        chk("idle_flush_blocks", {63'h0, ir32}, 64'h1);

        issue(0, MUL,    64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, 0, 1);
        issue(0, MULH,   64'h80000000, 64'h80000000, 64'h40000000, 0, 1);
        issue(0, MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 0, 1);
        issue(0, MULHSU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 0, 1);
        issue(0, DIV,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 0, 1);
        issue(0, REM,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 0, 1);
        issue(0, DIVU,   64'd100,      64'd7,        64'd14,       0, 1);
        issue(0, REMU,   64'd100,      64'd7,        64'd2,        0, 1);
        issue(0, DIVU,   64'd5,        64'd0,        64'hFFFFFFFF, 1, 1);
        issue(0, REMU,   64'd5,        64'd0,        64'd5,        1, 1);
        issue(0, DIV,    64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1, 1);
        issue(0, REM,    64'h80000000, 64'hFFFFFFFF, 64'h0,        1, 1);

        issue(1, MUL,    64'h7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 0, 1);
        issue(1, MULH,   64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, 0, 1);
        issue(1, MULHU,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 0, 1);
        issue(1, MULHSU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0, 1);
        issue(1, DIV,    64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFD, 0, 1);
        issue(1, REM,    64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFF, 0, 1);
        issue(1, DIVU,   64'd100, 64'd7, 64'd14, 0, 1);
        issue(1, REMU,   64'd100, 64'd7, 64'd2,  0, 1);
        issue(1, DIVU,   64'd5,   64'd0, 64'hFFFFFFFFFFFFFFFF, 1, 1);
        issue(1, REMU,   64'd5,   64'd0, 64'd5, 1, 1);
        issue(1, DIV,    64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1, 1);
        issue(1, REM,    64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, 1);

        // Hold in DONE with a pending op that must wait for the handshake.
        out_ready = 1'b0;
        issue(0, DIVU, 64'd100, 64'd7, 64'd14, 0, 1);
        iv32 = 1'b1; op_s = MUL; a_s = 64'd3; b_s = 64'd4;
        n = 0;
        while (!ov32 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached_done", {63'h0, ov32}, 64'h1);
        repeat (5) begin
            @(negedge clk);
            chk("hold_out_valid", {63'h0, ov32}, 64'h1);
            chk("hold_result", {32'h0, res32}, 64'd14);
            chk("hold_in_ready", {63'h0, ir32}, 64'h0);
        end
        out_ready = 1'b1;
        issue(0, MUL, 64'd3, 64'd4, 64'd12, 0, 1);

        // Flush ten cycles into CALC.
        issue(0, MUL, 64'd7, 64'd5, 64'd0, 0, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        abort_check("flush");
        issue(0, MUL, 64'd3, 64'd4, 64'd12, 0, 1);

        // Reset mid-CALC.
        issue(0, MUL, 64'd9, 64'd9, 64'd0, 0, 0);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        abort_check("reset");
        chk("reset_result", {32'h0, res32}, 64'h0);
        issue(0, MUL, 64'd3, 64'd4, 64'd12, 0, 1);

        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(q32.size() + q64.size()), 64'h0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
